// File: rtl/bridge_pkg.sv
//------------------------------------------------------------------------------
// Module : bridge_pkg
// Brief  : Shared types and response-word layout for the AHB-to-APB bridge.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    ACCESS    = 2'd2,
    RESP_WAIT = 2'd3
  } apb_state_t;

  localparam int BRIDGE_DATASIZE  = 32;
  localparam int BRIDGE_ADDRSIZE  = 32;
  localparam int BRIDGE_RESP_SIZE = BRIDGE_DATASIZE + 2;
  localparam int ERR_BIT          = BRIDGE_DATASIZE;
  localparam int WR_BIT           = BRIDGE_DATASIZE + 1;

  // Response word is {write_flag, err, rdata}; offsets follow the data width.
  function automatic int resp_size(input int datasize);
    return datasize + 2;
  endfunction

  function automatic int resp_err_bit(input int datasize);
    return datasize;
  endfunction

  function automatic int resp_wr_bit(input int datasize);
    return datasize + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_timeout_counter.sv
//------------------------------------------------------------------------------
// Module : apb_timeout_counter
// Brief  : Wait-state counter; expired flags TIMEOUT_CYCLES-1 stalled cycles.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Holds at the limit so a late enable can never wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_ctrl.sv
//------------------------------------------------------------------------------
// Module : apb_master_ctrl
// Brief  : APB-side sequencer: pops request FIFO, runs SETUP/ACCESS, pushes resp.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module apb_master_ctrl
  import bridge_pkg::*;
#(
  parameter int DATASIZE       = BRIDGE_DATASIZE,
  parameter int ADDRSIZE       = BRIDGE_ADDRSIZE,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int RESP_SIZE      = resp_size(DATASIZE)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic [ADDRSIZE-1:0]   addr,
  input  logic [DATASIZE-1:0]   wdata,
  input  logic [DATASIZE/8-1:0] strb,
  input  logic [2:0]            pprot,
  input  logic                  write_read,
  output logic                  rinc,
  input  logic                  resp_wfull,
  output logic                  resp_winc,
  output logic [RESP_SIZE-1:0]  resp_wdata,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDRSIZE-1:0]   PADDR,
  output logic [DATASIZE-1:0]   PWDATA,
  output logic [DATASIZE/8-1:0] PSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic [DATASIZE-1:0]   PRDATA,
  input  logic                  PSLVERR
);

  localparam int STRBSIZE = DATASIZE / 8;
  localparam int RESP_ERR = resp_err_bit(DATASIZE);
  localparam int RESP_WR  = resp_wr_bit(DATASIZE);

  apb_state_t            state_q,   state_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q,  pwrite_d;
  logic [ADDRSIZE-1:0]   paddr_q,   paddr_d;
  logic [DATASIZE-1:0]   pwdata_q,  pwdata_d;
  logic [STRBSIZE-1:0]   pstrb_q,   pstrb_d;
  logic [2:0]            pprot_q,   pprot_d;
  logic [RESP_SIZE-1:0]  resp_q,    resp_d;

  logic                  latch_req;
  logic                  push_resp;
  logic                  complete;
  logic                  tmo_en;
  logic                  tmo_expired;
  logic [RESP_SIZE-1:0]  cpl_word;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .en      (tmo_en),
    .clr     (latch_req),
    .expired (tmo_expired)
  );

  // A timed-out access reports an error with no read data.
  always_comb begin
    cpl_word           = '0;
    cpl_word[RESP_WR]  = pwrite_q;
    cpl_word[RESP_ERR] = PREADY ? PSLVERR : 1'b1;
    if (PREADY && !pwrite_q) begin
      cpl_word[DATASIZE-1:0] = PRDATA;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    push_resp = 1'b0;
    complete  = 1'b0;
    tmo_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          latch_req = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY || tmo_expired) begin
          complete = 1'b1;
          if (!resp_wfull) begin
            push_resp = 1'b1;
            if (transfer) begin
              latch_req = 1'b1;
              state_d   = SETUP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = RESP_WAIT;
          end
        end else begin
          tmo_en = 1'b1;
        end
      end
      RESP_WAIT: begin
        if (!resp_wfull) begin
          push_resp = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    resp_d    = resp_q;
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);

    if (latch_req) begin
      paddr_d  = addr;
      pwdata_d = wdata;
      pstrb_d  = write_read ? strb : '0;
      pprot_d  = pprot;
      pwrite_d = write_read;
    end
    if (complete) begin
      resp_d = cpl_word;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      resp_q    <= resp_d;
    end
  end

  // Handshake pulses are masked in the reset cycle so a dropped entry never pops or pushes.
  assign rinc       = PRESETn & latch_req;
  assign resp_winc  = PRESETn & push_resp;
  assign resp_wdata = complete ? cpl_word : resp_q;

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PPROT   = pprot_q;

endmodule

`default_nettype wire
